// File: rtl/mem_line_burst_bridge.sv
// Line-to-beat bridge between cache_L1 and a narrower valid/ready memory port.
// A whole-line fill or writeback becomes an ascending burst of beats; read
// beats are reassembled into a line and handed back with a one-cycle pulse.

package mem_line_burst_bridge_pkg;
  localparam int unsigned LINE_BITS     = 512;
  localparam int unsigned MEM_ADDR_BITS = 64;
  localparam int unsigned LINE_ADDR_W   = MEM_ADDR_BITS - $clog2(LINE_BITS / 8);

  typedef struct packed {
    logic                   mem_req_load;
    logic                   mem_req_store;
    logic [LINE_ADDR_W-1:0] mem_addr;
    logic [LINE_BITS-1:0]   mem_data_out;
  } mem_bus_req_t;

  typedef struct packed {
    logic                 mem_ready;
    logic [LINE_BITS-1:0] mem_data;
  } mem_bus_resp_t;
endpackage

module mem_line_burst_bridge #(
  parameter int unsigned CACHE_LINE_SIZE = mem_line_burst_bridge_pkg::LINE_BITS,
  parameter int unsigned MEM_BUS_WIDTH   = 128,
  parameter int unsigned ADDR_WIDTH      = mem_line_burst_bridge_pkg::MEM_ADDR_BITS
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  mem_line_burst_bridge_pkg::mem_bus_req_t   req,
  output mem_line_burst_bridge_pkg::mem_bus_resp_t  resp,
  output logic                                      mem_cmd_valid,
  input  logic                                      mem_cmd_ready,
  output logic                                      mem_cmd_write,
  output logic [ADDR_WIDTH-1:0]                     mem_cmd_addr,
  output logic [MEM_BUS_WIDTH-1:0]                  mem_cmd_wdata,
  input  logic                                      mem_rvalid,
  input  logic [MEM_BUS_WIDTH-1:0]                  mem_rdata
);

  localparam int unsigned BEATS    = CACHE_LINE_SIZE / MEM_BUS_WIDTH;
  localparam int unsigned LINE_OFF = $clog2(CACHE_LINE_SIZE / 8);
  localparam int unsigned BEAT_OFF = $clog2(MEM_BUS_WIDTH / 8);
  localparam int unsigned CW       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LAW      = ADDR_WIDTH - LINE_OFF;
  localparam logic [CW-1:0] LAST   = CW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST, RESP} state_t;

  state_t                     state, state_nxt;
  logic [LAW-1:0]             line_addr;
  logic [CACHE_LINE_SIZE-1:0] line_buf, line_nxt, data_q;
  logic [CW-1:0]              cmd_cnt, rsp_cnt, cmd_nxt;
  logic                       cmd_fire, rd_take;

  // Byte address of beat idx within the latched line, zero-extended.
  function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [LAW-1:0] la,
                                                      input logic [CW-1:0]  idx);
    beat_addr = ADDR_WIDTH'({la, {LINE_OFF{1'b0}}}) | (ADDR_WIDTH'(idx) << BEAT_OFF);
  endfunction

  // Handshake decode and the line buffer with the incoming read beat merged in.
  always_comb begin
    cmd_fire = mem_cmd_valid && mem_cmd_ready;
    rd_take  = (state == RD_BURST) && mem_rvalid;
    cmd_nxt  = cmd_cnt + CW'(1);
    line_nxt = line_buf;
    if (rd_take) line_nxt[rsp_cnt*MEM_BUS_WIDTH +: MEM_BUS_WIDTH] = mem_rdata;
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; store wins over load when both are requested.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req.mem_req_store)     state_nxt = WR_BURST;
        else if (req.mem_req_load) state_nxt = RD_BURST;
      end
      WR_BURST: if (cmd_fire && cmd_cnt == LAST) state_nxt = RESP;
      RD_BURST: if (rd_take && rsp_cnt == LAST)  state_nxt = RESP;
      RESP:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Command channel, beat counters, line assembly and returned-line register.
  // Command outputs only move on a handshake, so they hold while stalled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      line_addr     <= '0;
      line_buf      <= '0;
      data_q        <= '0;
      cmd_cnt       <= '0;
      rsp_cnt       <= '0;
      mem_cmd_valid <= 1'b0;
      mem_cmd_write <= 1'b0;
      mem_cmd_addr  <= '0;
      mem_cmd_wdata <= '0;
    end else begin
      line_buf <= line_nxt;
      case (state)
        IDLE: begin
          if (req.mem_req_store || req.mem_req_load) begin
            line_addr     <= req.mem_addr;
            cmd_cnt       <= '0;
            rsp_cnt       <= '0;
            mem_cmd_valid <= 1'b1;
            mem_cmd_write <= req.mem_req_store;
            mem_cmd_addr  <= beat_addr(req.mem_addr, '0);
            if (req.mem_req_store) begin
              line_buf      <= req.mem_data_out;
              mem_cmd_wdata <= req.mem_data_out[MEM_BUS_WIDTH-1:0];
            end else begin
              mem_cmd_wdata <= '0;
            end
          end
        end
        WR_BURST, RD_BURST: begin
          if (cmd_fire) begin
            if (cmd_cnt == LAST) begin
              mem_cmd_valid <= 1'b0;
            end else begin
              cmd_cnt      <= cmd_nxt;
              mem_cmd_addr <= beat_addr(line_addr, cmd_nxt);
              if (state == WR_BURST)
                mem_cmd_wdata <= line_buf[cmd_nxt*MEM_BUS_WIDTH +: MEM_BUS_WIDTH];
            end
          end
          if (rd_take) begin
            rsp_cnt <= rsp_cnt + CW'(1);
            if (rsp_cnt == LAST) data_q <= line_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Response port: pulse while in RESP, line held until the next fill completes.
  always_comb begin
    resp.mem_ready = (state == RESP);
    resp.mem_data  = data_q;
  end

endmodule

// File: tb/tb_mem_line_burst_bridge.sv
// Directed plus randomized bench for mem_line_burst_bridge with a memory
// responder and a line-level reference model.
module tb_mem_line_burst_bridge;
  import mem_line_burst_bridge_pkg::*;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  mem_bus_req_t        req;
  mem_bus_resp_t       resp;
  logic                mem_cmd_valid, mem_cmd_ready, mem_cmd_write;
  logic [63:0]         mem_cmd_addr;
  logic [127:0]        mem_cmd_wdata, mem_rdata;
  logic                mem_rvalid;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;

  mem_line_burst_bridge #(
    .CACHE_LINE_SIZE(512),
    .MEM_BUS_WIDTH  (128),
    .ADDR_WIDTH     (64)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .resp         (resp),
    .mem_cmd_valid(mem_cmd_valid),
    .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_write(mem_cmd_write),
    .mem_cmd_addr (mem_cmd_addr),
    .mem_cmd_wdata(mem_cmd_wdata),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [63:0] a; logic [127:0] d; } wr_t;
  typedef struct { logic [63:0] a; int unsigned due; } pend_t;

  logic [127:0] mem_model [logic [63:0]];
  wr_t          wr_log[$];
  logic [63:0]  rd_log[$];
  pend_t        pend[$];

  int unsigned  ready_mode = 0;
  int unsigned  lat_lo = 3, lat_hi = 3;
  int unsigned  rv_count = 0, last_rv_cyc = 0, pulse_count = 0, last_due = 0;
  bit           stray_go = 1'b0;
  logic [127:0] stray_data = '0;
  logic [511:0] exp_mem_data = '0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_addr(input logic [57:0] line, input int unsigned i);
    return 64'(line) * 64 + 64'(i) * 16;
  endfunction

  // Memory contents for addresses never written: a fixed function of the address.
  function automatic logic [127:0] mem_rd(input logic [63:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0], a[31:0] + 32'h1234_5678, a[15:0], a[31:16]};
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Memory side: decides ready and rvalid at each negedge for the next posedge,
  // logs handshakes, and checks command stability across stalls.
  initial begin
    bit           stalled_prev;
    logic [63:0]  a_prev;
    logic [127:0] d_prev;
    logic         w_prev;
    pend_t        p;
    int unsigned  due;
    stalled_prev = 1'b0; a_prev = '0; d_prev = '0; w_prev = 1'b0;
    mem_cmd_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (resp.mem_ready) pulse_count++;
      if (stalled_prev && reset) begin
        chk("stall_valid", mem_cmd_valid, 1);
        chk("stall_addr", mem_cmd_addr, a_prev);
        chk("stall_wdata", mem_cmd_wdata, d_prev);
        chk("stall_write", mem_cmd_write, w_prev);
      end
      case (ready_mode)
        0:       mem_cmd_ready = 1'b1;
        1:       mem_cmd_ready = (cyc % 2 == 0);
        default: mem_cmd_ready = ($urandom % 2 == 1);
      endcase
      stalled_prev = mem_cmd_valid && !mem_cmd_ready && reset;
      a_prev = mem_cmd_addr; d_prev = mem_cmd_wdata; w_prev = mem_cmd_write;
      if (mem_cmd_valid && mem_cmd_ready && reset) begin
        if (mem_cmd_write) begin
          wr_log.push_back('{a: mem_cmd_addr, d: mem_cmd_wdata});
          mem_model[mem_cmd_addr] = mem_cmd_wdata;
        end else begin
          rd_log.push_back(mem_cmd_addr);
          due = cyc + $urandom_range(lat_hi, lat_lo);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          pend.push_back('{a: mem_cmd_addr, due: due});
        end
      end
      mem_rvalid = 1'b0;
      if (stray_go) begin
        mem_rvalid = 1'b1;
        mem_rdata  = stray_data;
        stray_go   = 1'b0;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        mem_rvalid  = 1'b1;
        mem_rdata   = mem_rd(p.a);
        rv_count++;
        last_rv_cyc = cyc;
      end
    end
  end

  // One cache_L1 transaction: hold the request until mem_ready, then check
  // the beats seen on the memory port and the returned line.
  task automatic run_txn(input bit ld, input bit st, input logic [57:0] line,
                         input logic [511:0] data);
    int unsigned  c0, pc0, dcyc;
    bit           done;
    logic [511:0] got, exp_line;
    wr_log.delete(); rd_log.delete();
    pc0 = pulse_count; done = 1'b0; got = '0; dcyc = 0;
    @(posedge clock); #1;
    req.mem_req_load = ld; req.mem_req_store = st;
    req.mem_addr = line;   req.mem_data_out = data;
    c0 = cyc;
    @(posedge clock); #1;
    chk("cmd_valid_after_accept", mem_cmd_valid, 1);
    req.mem_addr = 58'($urandom); req.mem_data_out = rand512();
    for (int k = 0; k < 300 && !done; k++) begin
      if (resp.mem_ready) begin
        done = 1'b1; got = resp.mem_data; dcyc = cyc;
      end else begin
        @(posedge clock); #1;
      end
    end
    chk("done_in_time", done, 1);
    req = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("ready_pulses", pulse_count - pc0, 1);
    chk("ready_low_after", resp.mem_ready, 0);
    if (st) begin
      chk("wr_beats", wr_log.size(), 4);
      chk("wr_no_reads", rd_log.size(), 0);
      for (int unsigned i = 0; i < 4 && i < wr_log.size(); i++) begin
        chk($sformatf("wr_addr%0d", i), wr_log[i].a, exp_addr(line, i));
        chk($sformatf("wr_data%0d", i), wr_log[i].d, data[i*128 +: 128]);
      end
      if (ready_mode == 0) chk("wr_latency", dcyc - c0, 5);
      chk("wr_keeps_mem_data", got, exp_mem_data);
    end else begin
      chk("rd_beats", rd_log.size(), 4);
      chk("rd_no_writes", wr_log.size(), 0);
      exp_line = '0;
      for (int unsigned i = 0; i < 4; i++) begin
        if (i < rd_log.size()) chk($sformatf("rd_addr%0d", i), rd_log[i], exp_addr(line, i));
        exp_line[i*128 +: 128] = mem_rd(exp_addr(line, i));
      end
      chk("rd_line", got, exp_line);
      chk("rd_latency", dcyc, last_rv_cyc + 1);
      exp_mem_data = exp_line;
    end
    chk("mem_data_held", resp.mem_data, exp_mem_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [511:0] pat;
    int unsigned  rv0, pc0;
    bit           ok;
    req = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", mem_cmd_valid, 0);
    chk("rst_write", mem_cmd_write, 0);
    chk("rst_addr", mem_cmd_addr, 0);
    chk("rst_wdata", mem_cmd_wdata, 0);
    chk("rst_ready", resp.mem_ready, 0);
    chk("rst_data", resp.mem_data, 0);
    reset = 1'b1;

    // Fill of line 0x40, rvalid three cycles after each command.
    ready_mode = 0; lat_lo = 3; lat_hi = 3;
    run_txn(1'b1, 1'b0, 58'h40, '0);
    chk("fill_addr0", exp_addr(58'h40, 0), 64'h1000);

    // Writeback of line 0x41 with ready toggling.
    ready_mode = 1;
    pat = rand512();
    run_txn(1'b0, 1'b1, 58'h41, pat);

    // Load and store together: store wins.
    ready_mode = 0;
    run_txn(1'b1, 1'b1, 58'h7, rand512());

    // Writeback then fill of the same line returns the written data.
    pat = rand512();
    run_txn(1'b0, 1'b1, 58'h123, pat);
    lat_lo = 1; lat_hi = 4;
    run_txn(1'b1, 1'b0, 58'h123, '0);
    chk("wb_fill_roundtrip", resp.mem_data, pat);

    // Reset after two returned beats of a fill.
    lat_lo = 3; lat_hi = 3;
    rv0 = rv_count; pc0 = pulse_count; ok = 1'b0;
    @(posedge clock); #1;
    req.mem_req_load = 1'b1; req.mem_addr = 58'h55;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(posedge clock); #1;
      if (rv_count - rv0 >= 2) ok = 1'b1;
    end
    chk("two_beats_seen", ok, 1);
    reset = 1'b0; req = '0;
    #1;
    chk("mid_rst_valid", mem_cmd_valid, 0);
    chk("mid_rst_write", mem_cmd_write, 0);
    chk("mid_rst_addr", mem_cmd_addr, 0);
    chk("mid_rst_wdata", mem_cmd_wdata, 0);
    chk("mid_rst_ready", resp.mem_ready, 0);
    chk("mid_rst_data", resp.mem_data, 0);
    exp_mem_data = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(posedge clock); #1;
      if (pend.size() == 0) ok = 1'b1;
    end
    chk("late_beats_drained", ok, 1);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_no_pulse", pulse_count - pc0, 0);
    chk("late_rvalid_ignored", resp.mem_data, exp_mem_data);
    chk("late_rvalid_idle", mem_cmd_valid, 0);
    run_txn(1'b1, 1'b0, 58'h55, '0);

    // Stray rvalid while idle.
    pc0 = pulse_count;
    @(posedge clock); #1;
    stray_data = 128'hDEAD; stray_go = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("stray_data_kept", resp.mem_data, exp_mem_data);
    chk("stray_no_pulse", pulse_count - pc0, 0);
    chk("stray_no_cmd", mem_cmd_valid, 0);

    // Address extremes.
    run_txn(1'b1, 1'b0, 58'h0, '0);
    run_txn(1'b0, 1'b1, {58{1'b1}}, rand512());
    run_txn(1'b1, 1'b0, {58{1'b1}}, '0);

    // Randomized mix of fills and writebacks.
    for (int r = 0; r < 12; r++) begin
      ready_mode = $urandom_range(2, 0);
      lat_lo = $urandom_range(2, 1);
      lat_hi = lat_lo + $urandom_range(3, 0);
      if ($urandom_range(1, 0) == 1)
        run_txn(1'b0, 1'b1, 58'($urandom_range(15, 0)), rand512());
      else
        run_txn(1'b1, 1'b0, 58'($urandom_range(15, 0)), '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
